// File: rtl/tdm_pkg.sv
// tdm_pkg: shared types, defaults and helpers for the TDM demux
package tdm_pkg;
    typedef enum logic {HUNT, LOCKED} state_t;
    localparam int NSLOTS_DEF = 4;
    function automatic int slot_w(input int n);
        return $clog2(n);
    endfunction
endpackage

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: slot index counter with clear, load-to-1, enable and wrap
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int NSLOTS = NSLOTS_DEF,
    localparam int SLOT_W = slot_w(NSLOTS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              load1,
    input  logic              clr,
    output logic [SLOT_W-1:0] slot,
    output logic              last
);
    assign last = slot == SLOT_W'(NSLOTS - 1);
    always_ff @(posedge clk) begin
        if (!rst_n || clr) slot <= '0;
        else if (load1) slot <= SLOT_W'(1);
        else if (en) slot <= last ? '0 : slot + SLOT_W'(1);
    end
endmodule

// File: rtl/tdm_demux_1_4.sv
// tdm_demux_1_4: rebuilds NSLOTS parallel channels from a framed TDM stream
module tdm_demux_1_4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int NSLOTS = NSLOTS_DEF,
    localparam int SLOT_W = slot_w(NSLOTS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        din,
    input  logic                    din_valid,
    input  logic                    fsync,
    output logic [NSLOTS*WIDTH-1:0] dout,
    output logic                    frame_valid,
    output logic [SLOT_W-1:0]       slot,
    output logic                    locked,
    output logic                    sync_err
);
    state_t state, nstate;
    logic [NSLOTS-2:0][WIDTH-1:0] shadow;
    logic ld, en, clr, wr, fv_d, err_d, last;

    tdm_slot_counter #(.NSLOTS(NSLOTS)) u_cnt (
        .clk(clk), .rst_n(rst_n), .en(en), .load1(ld), .clr(clr), .slot(slot), .last(last)
    );

    assign locked = state == LOCKED;

    always_comb begin
        nstate = state;
        ld = 1'b0;
        en = 1'b0;
        clr = 1'b0;
        wr = 1'b0;
        fv_d = 1'b0;
        err_d = 1'b0;
        if (din_valid) begin
            if (state == HUNT) begin
                ld = fsync;
                nstate = fsync ? LOCKED : HUNT;
            end else if (fsync) begin
                ld = 1'b1;
                err_d = slot != '0;
            end else if (slot == '0) begin
                err_d = 1'b1;
                clr = 1'b1;
                nstate = HUNT;
            end else begin
                en = 1'b1;
                wr = !last;
                fv_d = last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= HUNT;
        else state <= nstate;
    end

    // The final slot goes straight to dout, so shadow holds only slots 0..NSLOTS-2
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow <= '0;
            dout <= '0;
            frame_valid <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            frame_valid <= fv_d;
            sync_err <= err_d;
            if (fv_d) dout <= {din, shadow};
            for (int k = 0; k < NSLOTS - 1; k++)
                if ((ld && k == 0) || (wr && slot == SLOT_W'(k))) shadow[k] <= din;
        end
    end
endmodule

// File: tb/tb_tdm_demux_1_4.sv
// tb_tdm_demux_1_4: scoreboard bench for the TDM demux
module tb_tdm_demux_1_4;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [0:0] din;
    logic       din_valid;
    logic       fsync;
    logic [3:0] dout;
    logic       frame_valid;
    logic [1:0] slot;
    logic       locked;
    logic       sync_err;

    int total = 0;
    int bad = 0;
    int fv_cnt = 0;
    int err_cnt = 0;
    logic [3:0] exp_q[$];

    tdm_demux_1_4 #(.WIDTH(1), .NSLOTS(4)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .fsync(fsync),
        .dout(dout), .frame_valid(frame_valid), .slot(slot), .locked(locked), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        logic [3:0] e;
        @(posedge clk);
        #1;
        if (frame_valid) begin
            fv_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL frame_unexpected dout=%b want=none", dout);
            end else begin
                e = exp_q.pop_front();
                if (dout !== e) begin
                    bad++;
                    $display("FAIL frame_data dout=%b want=%b", dout, e);
                end
            end
        end
        if (sync_err) err_cnt++;
        if (frame_valid && sync_err) begin
            total++;
            bad++;
            $display("FAIL pulse_overlap frame_valid=1 sync_err=1 want not both");
        end
    endtask

    task automatic beat(input logic d, input logic f);
        din = d;
        fsync = f;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        fsync = 1'b0;
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(2);
        total++;
        if ({dout, frame_valid, sync_err, locked, slot} !== 9'b0) begin
            bad++;
            $display("FAIL reset_state dout=%b fv=%b se=%b lk=%b slot=%0d want all 0", dout, frame_valid, sync_err, locked, slot);
        end
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_basic();
        fv_cnt = 0;
        err_cnt = 0;
        exp_q.push_back(4'b1101);
        beat(1, 1);
        beat(0, 0);
        beat(1, 0);
        total++;
        if (fv_cnt !== 0 || dout !== 4'b0000) begin
            bad++;
            $display("FAIL basic_early fv_cnt=%0d dout=%b want 0 0000", fv_cnt, dout);
        end
        beat(1, 0);
        total++;
        if (frame_valid !== 1'b1) begin
            bad++;
            $display("FAIL basic_latency frame_valid=%b want 1", frame_valid);
        end
        idle(1);
        total++;
        if (frame_valid !== 1'b0 || dout !== 4'b1101 || slot !== 2'd0 || locked !== 1'b1) begin
            bad++;
            $display("FAIL basic_after fv=%b dout=%b slot=%0d lk=%b want 0 1101 0 1", frame_valid, dout, slot, locked);
        end
        chk("basic_err", err_cnt, 0);
    endtask

    task automatic test_hunt();
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        fv_cnt = 0;
        err_cnt = 0;
        beat(0, 0);
        beat(1, 0);
        beat(1, 0);
        total++;
        if (locked !== 1'b0 || slot !== 2'd0 || fv_cnt !== 0 || err_cnt !== 0) begin
            bad++;
            $display("FAIL hunt_drop lk=%b slot=%0d fv=%0d err=%0d want 0 0 0 0", locked, slot, fv_cnt, err_cnt);
        end
        exp_q.push_back(4'b0010);
        beat(0, 1);
        beat(1, 0);
        beat(0, 0);
        beat(0, 0);
        idle(1);
        chk("hunt_dout", int'(dout), 4'b0010);
        chk("hunt_pulses", fv_cnt, 1);
        chk("hunt_err", err_cnt, 0);
    endtask

    task automatic test_gap();
        fv_cnt = 0;
        err_cnt = 0;
        exp_q.push_back(4'b1011);
        beat(1, 1);
        beat(1, 0);
        idle(3);
        total++;
        if (slot !== 2'd2 || dout !== 4'b0010 || fv_cnt !== 0) begin
            bad++;
            $display("FAIL gap_hold slot=%0d dout=%b fv=%0d want 2 0010 0", slot, dout, fv_cnt);
        end
        beat(0, 0);
        beat(1, 0);
        exp_q.push_back(4'b0110);
        beat(0, 1);
        beat(1, 0);
        beat(1, 0);
        beat(0, 0);
        idle(1);
        chk("gap_dout", int'(dout), 4'b0110);
        chk("gap_pulses", fv_cnt, 2);
        chk("gap_err", err_cnt, 0);
    endtask

    task automatic test_early_sync();
        fv_cnt = 0;
        err_cnt = 0;
        beat(1, 1);
        beat(0, 0);
        beat(1, 1);
        total++;
        if (sync_err !== 1'b1 || locked !== 1'b1 || slot !== 2'd1 || dout !== 4'b0110) begin
            bad++;
            $display("FAIL early_sync se=%b lk=%b slot=%0d dout=%b want 1 1 1 0110", sync_err, locked, slot, dout);
        end
        exp_q.push_back(4'b0111);
        beat(1, 0);
        beat(1, 0);
        beat(0, 0);
        idle(1);
        chk("early_pulses", fv_cnt, 1);
        chk("early_err", err_cnt, 1);
        chk("early_dout", int'(dout), 4'b0111);
    endtask

    task automatic test_lost_sync();
        fv_cnt = 0;
        err_cnt = 0;
        beat(1, 0);
        total++;
        if (sync_err !== 1'b1 || locked !== 1'b0 || slot !== 2'd0 || dout !== 4'b0111) begin
            bad++;
            $display("FAIL lost_sync se=%b lk=%b slot=%0d dout=%b want 1 0 0 0111", sync_err, locked, slot, dout);
        end
        beat(1, 0);
        beat(1, 0);
        beat(1, 0);
        total++;
        if (err_cnt !== 1 || fv_cnt !== 0 || locked !== 1'b0 || slot !== 2'd0) begin
            bad++;
            $display("FAIL lost_drop err=%0d fv=%0d lk=%b slot=%0d want 1 0 0 0", err_cnt, fv_cnt, locked, slot);
        end
        exp_q.push_back(4'b1100);
        beat(0, 1);
        beat(0, 0);
        beat(1, 0);
        beat(1, 0);
        idle(1);
        chk("lost_relock_pulses", fv_cnt, 1);
        chk("lost_relock_dout", int'(dout), 4'b1100);
    endtask

    task automatic test_reset_mid();
        fv_cnt = 0;
        err_cnt = 0;
        beat(1, 1);
        beat(1, 0);
        rst_n = 1'b0;
        beat(1, 0);
        rst_n = 1'b1;
        total++;
        if (dout !== 4'b0000 || locked !== 1'b0 || slot !== 2'd0 || frame_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid dout=%b lk=%b slot=%0d fv=%b want 0000 0 0 0", dout, locked, slot, frame_valid);
        end
        beat(1, 0);
        beat(1, 0);
        idle(2);
        chk("reset_mid_pulses", fv_cnt, 0);
        chk("reset_mid_locked", int'(locked), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        din = 1'b0;
        din_valid = 1'b0;
        fsync = 1'b0;
        test_reset();
        test_basic();
        test_hunt();
        test_gap();
        test_early_sync();
        test_lost_sync();
        test_reset_mid();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
